// File: rtl/vend_txn_controller.sv
// vend_txn_controller: coin credit, selection check, vend pulse, change return.
// Define VEND_TIMEOUT_EN to auto-refund after TIMEOUT_CYC idle cycles in CREDIT.
module vend_txn_controller #(
  parameter int PRICE_CHOC  = 10,
  parameter int PRICE_ICE   = 20,
  parameter int PRICE_COLD  = 50,
  parameter int CREDIT_W    = 6,
  parameter int STOCK_W     = 4,
  parameter int STOCK_INIT  = 5,
  parameter int TIMEOUT_CYC = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                sel_valid,
  input  logic [1:0]          select,
  input  logic                refill,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend_valid,
  output logic [1:0]          vend_item,
  output logic                chg_valid,
  output logic [1:0]          chg_code,
  input  logic                chg_ready,
  output logic                busy,
  output logic                coin_reject,
  output logic                err_funds,
  output logic                err_nostock
);

  typedef enum logic [1:0] {
    S_IDLE, S_CREDIT, S_VEND, S_CHANGE
  } state_t;

  localparam logic [STOCK_W-1:0] SINIT = STOCK_W'(STOCK_INIT);

  function automatic logic [CREDIT_W-1:0] coin_val(input logic [1:0] c);
    unique case (c)
      2'b00:   return CREDIT_W'(5);
      2'b01:   return CREDIT_W'(10);
      2'b10:   return CREDIT_W'(20);
      default: return CREDIT_W'(50);
    endcase
  endfunction

  function automatic logic [CREDIT_W-1:0] price(input logic [1:0] i);
    unique case (i)
      2'b00:   return CREDIT_W'(PRICE_CHOC);
      2'b01:   return CREDIT_W'(PRICE_ICE);
      default: return CREDIT_W'(PRICE_COLD);
    endcase
  endfunction

  // Largest returnable coin not exceeding the remaining credit.
  function automatic logic [1:0] chg_pick(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(20)) return 2'b10;
    if (c >= CREDIT_W'(10)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [CREDIT_W-1:0] chg_val(input logic [1:0] c);
    unique case (c)
      2'b10:   return CREDIT_W'(20);
      2'b01:   return CREDIT_W'(10);
      default: return CREDIT_W'(5);
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q [3];
  logic [STOCK_W-1:0]  stock_d [3];
  logic                vend_valid_q, vend_valid_d;
  logic [1:0]          vend_item_q, vend_item_d;
  logic                chg_valid_q, chg_valid_d;
  logic [1:0]          chg_code_q, chg_code_d;
  logic                busy_q, busy_d;
  logic                coin_reject_q, coin_reject_d;
  logic                err_funds_q, err_funds_d;
  logic                err_nostock_q, err_nostock_d;
  logic [STOCK_W-1:0]  sel_stock;
  logic [CREDIT_W:0]   coin_sum;

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    stock_d       = stock_q;
    vend_valid_d  = 1'b0;
    vend_item_d   = 2'b00;
    chg_valid_d   = 1'b0;
    chg_code_d    = 2'b00;
    coin_reject_d = 1'b0;
    err_funds_d   = 1'b0;
    err_nostock_d = 1'b0;
    sel_stock     = '0;
    for (int i = 0; i < 3; i++)
      if (select == 2'(i)) sel_stock = stock_q[i];
    coin_sum = {1'b0, credit_q} + {1'b0, coin_val(coin_code)};

    unique case (state_q)
      S_IDLE, S_CREDIT: begin
        if (sel_valid) begin
          // Selection wins; a simultaneous coin is refused.
          coin_reject_d = coin_valid;
          if (select == 2'b11) begin
            if (state_q == S_CREDIT) begin
              state_d     = S_CHANGE;
              chg_valid_d = 1'b1;
              chg_code_d  = chg_pick(credit_q);
            end
          end else if (sel_stock == '0) begin
            err_nostock_d = 1'b1;
          end else if (credit_q < price(select)) begin
            err_funds_d = 1'b1;
          end else begin
            state_d      = S_VEND;
            vend_valid_d = 1'b1;
            vend_item_d  = select;
            credit_d     = credit_q - price(select);
            for (int i = 0; i < 3; i++)
              if (select == 2'(i))
                stock_d[i] = stock_q[i] - STOCK_W'(1);
          end
        end else if (coin_valid) begin
          if (coin_sum[CREDIT_W]) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = S_CREDIT;
          end
        end
        if (state_q == S_IDLE && refill)
          for (int i = 0; i < 3; i++) stock_d[i] = SINIT;
      end
      S_VEND: begin
        coin_reject_d = coin_valid;
        if (credit_q != '0) begin
          state_d     = S_CHANGE;
          chg_valid_d = 1'b1;
          chg_code_d  = chg_pick(credit_q);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHANGE: begin
        coin_reject_d = coin_valid;
        chg_valid_d   = 1'b1;
        chg_code_d    = chg_code_q;
        if (chg_valid_q && chg_ready) begin
          credit_d = credit_q - chg_val(chg_code_q);
          if (credit_d == '0) begin
            state_d     = S_IDLE;
            chg_valid_d = 1'b0;
            chg_code_d  = 2'b00;
          end else begin
            chg_code_d = chg_pick(credit_d);
          end
        end
      end
    endcase

`ifdef VEND_TIMEOUT_EN
    tmo_d = '0;
    if (state_q == S_CREDIT && !coin_valid && !sel_valid) begin
      if (tmo_q == TMO_LAST) begin
        state_d     = S_CHANGE;
        chg_valid_d = 1'b1;
        chg_code_d  = chg_pick(credit_q);
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
`endif

    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      for (int i = 0; i < 3; i++) stock_q[i] <= SINIT;
      vend_valid_q  <= 1'b0;
      vend_item_q   <= 2'b00;
      chg_valid_q   <= 1'b0;
      chg_code_q    <= 2'b00;
      busy_q        <= 1'b0;
      coin_reject_q <= 1'b0;
      err_funds_q   <= 1'b0;
      err_nostock_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      stock_q       <= stock_d;
      vend_valid_q  <= vend_valid_d;
      vend_item_q   <= vend_item_d;
      chg_valid_q   <= chg_valid_d;
      chg_code_q    <= chg_code_d;
      busy_q        <= busy_d;
      coin_reject_q <= coin_reject_d;
      err_funds_q   <= err_funds_d;
      err_nostock_q <= err_nostock_d;
    end
  end

`ifdef VEND_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  assign credit      = credit_q;
  assign vend_valid  = vend_valid_q;
  assign vend_item   = vend_item_q;
  assign chg_valid   = chg_valid_q;
  assign chg_code    = chg_code_q;
  assign busy        = busy_q;
  assign coin_reject = coin_reject_q;
  assign err_funds   = err_funds_q;
  assign err_nostock = err_nostock_q;

endmodule

// File: tb/tb_vend_txn_controller.sv
// Bench for vend_txn_controller: directed scenarios then random traffic
// against a credit/stock/phase reference model.
module tb_vend_txn_controller;
  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid, sel_valid, refill, chg_ready;
  logic [1:0] coin_code, select;
  logic [5:0] credit;
  logic       vend_valid, chg_valid, busy;
  logic [1:0] vend_item, chg_code;
  logic       coin_reject, err_funds, err_nostock;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: credit in cents, stock per item, and the phase flags.
  int m_credit;
  int m_stock [3];
  bit m_vend, m_ret;
  int m_idle;
  bit e_vend, e_rej, e_funds, e_nost;
  int e_item;

  always #5 clk = ~clk;

  vend_txn_controller dut (
    .clk(clk), .reset(reset),
    .coin_valid(coin_valid), .coin_code(coin_code),
    .sel_valid(sel_valid), .select(select), .refill(refill),
    .credit(credit), .vend_valid(vend_valid), .vend_item(vend_item),
    .chg_valid(chg_valid), .chg_code(chg_code), .chg_ready(chg_ready),
    .busy(busy), .coin_reject(coin_reject),
    .err_funds(err_funds), .err_nostock(err_nostock)
  );

  function automatic int coin_value(int c);
    case (c)
      0: return 5;
      1: return 10;
      2: return 20;
      default: return 50;
    endcase
  endfunction

  function automatic int price(int i);
    case (i)
      0: return 10;
      1: return 20;
      default: return 50;
    endcase
  endfunction

  function automatic int change_of(int cr);
    return (cr >= 20) ? 20 : (cr >= 10) ? 10 : 5;
  endfunction

  function automatic int code_of(int v);
    return (v == 20) ? 2 : (v == 10) ? 1 : 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0;
    for (int i = 0; i < 3; i++) m_stock[i] = 5;
    m_vend = 0; m_ret = 0; m_idle = 0;
    e_vend = 0; e_rej = 0; e_funds = 0; e_nost = 0; e_item = 0;
  endtask

  task automatic model_step(bit cv, int cc, bit sv, int sl, bit rf, bit cr);
    int pre;
    pre = m_credit;
    e_vend = 0; e_rej = 0; e_funds = 0; e_nost = 0;
    if (m_vend) begin
      m_vend = 0; m_idle = 0;
      e_rej = cv;
      m_ret = (m_credit > 0);
    end else if (m_ret) begin
      m_idle = 0;
      e_rej = cv;
      if (cr) begin
        m_credit -= change_of(m_credit);
        if (m_credit == 0) m_ret = 0;
      end
    end else begin
      if (sv) begin
        e_rej = cv;
        if (sl == 3) begin
          if (pre > 0) m_ret = 1;
        end else if (m_stock[sl] == 0) e_nost = 1;
        else if (m_credit < price(sl)) e_funds = 1;
        else begin
          m_credit -= price(sl);
          m_stock[sl]--;
          m_vend = 1; e_vend = 1; e_item = sl;
        end
      end else if (cv) begin
        if (m_credit + coin_value(cc) > 63) e_rej = 1;
        else m_credit += coin_value(cc);
      end
      if (pre == 0 && rf)
        for (int i = 0; i < 3; i++) m_stock[i] = 5;
`ifdef VEND_TIMEOUT_EN
      if (pre > 0 && !cv && !sv) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_ret = 1; m_idle = 0;
        end
      end else m_idle = 0;
`endif
    end
  endtask

  task automatic check_all();
    chk("credit", 32'(credit), 32'(m_credit));
    chk("vend_valid", 32'(vend_valid), 32'(e_vend));
    if (e_vend) chk("vend_item", 32'(vend_item), 32'(e_item));
    chk("chg_valid", 32'(chg_valid), 32'(m_ret));
    chk("chg_code", 32'(chg_code),
        m_ret ? 32'(code_of(change_of(m_credit))) : 32'd0);
    chk("busy", 32'(busy), 32'(m_vend || m_ret));
    chk("coin_reject", 32'(coin_reject), 32'(e_rej));
    chk("err_funds", 32'(err_funds), 32'(e_funds));
    chk("err_nostock", 32'(err_nostock), 32'(e_nost));
  endtask

  task automatic cyc(bit cv, int cc, bit sv, int sl, bit rf, bit cr);
    coin_valid = cv; coin_code = 2'(cc);
    sel_valid = sv; select = 2'(sl);
    refill = rf; chg_ready = cr;
    @(posedge clk);
    model_step(cv, cc, sv, sl, rf, cr);
    @(negedge clk);
    check_all();
  endtask

  task automatic t_coin(int cc); cyc(1, cc, 0, 0, 0, 0); endtask
  task automatic t_sel(int sl);  cyc(0, 0, 1, sl, 0, 0); endtask
  task automatic t_idle(bit cr); cyc(0, 0, 0, 0, 0, cr); endtask

  initial begin
    reset = 1'b1;
    coin_valid = 0; coin_code = 0; sel_valid = 0;
    select = 0; refill = 0; chg_ready = 0;
    model_reset();
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // 1: exact payment for chocolate
    t_coin(1);
    t_sel(0);
    chk("t1_vend", 32'(vend_valid), 32'd1);
    chk("t1_item", 32'(vend_item), 32'd0);
    t_idle(0);
    chk("t1_nochg", 32'(chg_valid), 32'd0);

    // 2: overpay ice cream, change 20 + 20
    t_coin(3); t_coin(1);
    t_sel(1);
    chk("t2_item", 32'(vend_item), 32'd1);
    t_idle(1);
    chk("t2_beat1", 32'(chg_code), 32'd2);
    t_idle(1);
    chk("t2_beat2", 32'(chg_code), 32'd2);
    t_idle(1);
    chk("t2_done", 32'(credit), 32'd0);

    // 3: insufficient funds then cancel
    t_coin(1);
    t_sel(2);
    chk("t3_funds", 32'(err_funds), 32'd1);
    t_sel(3);
    chk("t3_chg10", 32'(chg_code), 32'd1);
    t_idle(1);

    // 4: overflow coin rejected, change held while not ready
    t_coin(3); t_coin(1); t_coin(0);
    chk("t4_reject", 32'(coin_reject), 32'd1);
    chk("t4_credit", 32'(credit), 32'd60);
    t_sel(3);
    for (int i = 0; i < 5; i++) t_idle(0);
    chk("t4_hold", 32'(chg_code), 32'd2);
    for (int i = 0; i < 3; i++) t_idle(1);

    // 5: drain chocolate stock, then refill
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      t_coin(1); t_sel(0); t_idle(0);
    end
    t_coin(1);
    t_sel(0);
    chk("t5_nostock", 32'(err_nostock), 32'd1);
    t_sel(3);
    t_idle(1);
    cyc(0, 0, 0, 0, 1, 0);
    t_coin(1);
    t_sel(0);
    chk("t5_refilled", 32'(vend_valid), 32'd1);
    t_idle(0);

    // 6: asynchronous reset in the middle of change return
    t_coin(2);
    t_sel(3);
    t_idle(0);
    coin_valid = 0; sel_valid = 0; refill = 0; chg_ready = 0;
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;

    t_coin(2);
    for (int i = 0; i < TMO - 1; i++) t_idle(0);
`ifdef VEND_TIMEOUT_EN
    chk("tmo_early", 32'(chg_valid), 32'd0);
    t_idle(0);
    chk("tmo_refund", 32'(chg_valid), 32'd1);
    chk("tmo_code", 32'(chg_code), 32'd2);
    t_idle(1);
`else
    for (int i = 0; i < 50; i++) t_idle(0);
    chk("no_tmo", 32'(chg_valid), 32'd0);
    chk("no_tmo_credit", 32'(credit), 32'd20);
    t_sel(3);
    t_idle(1);
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 3),
          $urandom_range(0, 9) < 2, $urandom_range(0, 3),
          $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
